// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: frame controller state encodings and frame size.
package spi_pkg;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = 4;

    // Count value on which the final edge of a byte arrives
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_ADDR  = 3'd1;
    localparam logic [2:0] ST_GOT_ADDR  = 3'd2;
    localparam logic [2:0] ST_READ_LOAD = 3'd3;
    localparam logic [2:0] ST_READ_SEND = 3'd4;
    localparam logic [2:0] ST_WRITE_GET = 3'd5;
    localparam logic [2:0] ST_WRITE_DM  = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for SPI frame bytes; clear wins over enable and the count saturates.
module spi_bit_counter
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: address byte, R/W decision, then one data byte in or out.
module spi_frame_ctrl
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       cs_cond,
    input  logic       sr_lsb,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic [2:0] state
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;

    spi_bit_counter u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cnt)
    );

    // Held clear outside the counting states, so every counting state starts from 0
    assign cnt_clr = !((state_q == ST_GET_ADDR) || (state_q == ST_READ_SEND) ||
                       (state_q == ST_WRITE_GET));

    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE:      if (!cs_cond) state_d = ST_GET_ADDR;
            ST_GET_ADDR:  if (sclk_pos) begin
                              cnt_en = 1'b1;
                              if (cnt == LAST_CNT) state_d = ST_GOT_ADDR;
                          end
            ST_GOT_ADDR:  state_d = sr_lsb ? ST_READ_LOAD : ST_WRITE_GET;
            ST_READ_LOAD: state_d = ST_READ_SEND;
            ST_READ_SEND: if (sclk_neg) begin
                              cnt_en = 1'b1;
                              if (cnt == LAST_CNT) state_d = ST_DONE;
                          end
            ST_WRITE_GET: if (sclk_pos) begin
                              cnt_en = 1'b1;
                              if (cnt == LAST_CNT) state_d = ST_WRITE_DM;
                          end
            ST_WRITE_DM:  state_d = ST_DONE;
            ST_DONE:      state_d = ST_DONE;
            default:      state_d = ST_IDLE;
        endcase
        // Chip-select release aborts the frame ahead of any edge in the same cycle
        if (cs_cond && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign addr_we   = (state_q == ST_GOT_ADDR);
    assign sr_we     = (state_q == ST_READ_LOAD);
    assign dm_we     = (state_q == ST_WRITE_DM);
    assign miso_buff = (state_q == ST_READ_SEND);
    assign state     = state_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: write, read, abort, edge filtering, reset and priority.
module tb_spi_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic       cs_cond = 1'b1;
    logic       sr_lsb = 1'b0;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_buff;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int n_addr = 0;
    int n_sr = 0;
    int n_dm = 0;
    int n_miso = 0;

    spi_frame_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .cs_cond   (cs_cond),
        .sr_lsb    (sr_lsb),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .state     (state)
    );

    always #5 clk = ~clk;

    // One clock with the given edge pulses; tallies enable pulses seen after the edge
    task automatic cyc(input logic p, input logic n);
        sclk_pos = p;
        sclk_neg = n;
        @(posedge clk);
        #1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        n_addr += int'(addr_we);
        n_sr   += int'(sr_we);
        n_dm   += int'(dm_we);
        n_miso += int'(miso_buff);
    endtask

    task automatic clear_tallies();
        n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0;
    endtask

    // Start a frame and clock in the address byte with the given R/W bit
    task automatic send_addr(input logic rd);
        cs_cond = 1'b0;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        sr_lsb = rd;
        cyc(1'b0, 1'b0);
        sr_lsb = 1'b0;
    endtask

    task automatic end_frame();
        cs_cond = 1'b1;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs_cond = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        checks++;
        if (state !== 3'd0 || {addr_we, sr_we, dm_we, miso_buff} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outs=%b required state=0 outs=0000",
                     state, {addr_we, sr_we, dm_we, miso_buff});
        end
        cs_cond = 1'b1;
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_cs_high: state=%0d required 0", state);
        end
    endtask

    task automatic test_write_frame();
        clear_tallies();
        cs_cond = 1'b0;
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL wr_enter_get_addr: state=%0d required 1", state);
        end
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd1 || addr_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr_7th: state=%0d addr_we=%b required 1/0", state, addr_we);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd2 || addr_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_latency: state=%0d addr_we=%b required 2/1", state, addr_we);
        end
        sr_lsb = 1'b0;
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL wr_goto_write_get: state=%0d required 5", state);
        end
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd5 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_data_7th: state=%0d dm_we=%b required 5/0", state, dm_we);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd6 || dm_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_dm_latency: state=%0d dm_we=%b required 6/1", state, dm_we);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        checks++;
        if (state !== 3'd7) begin
            errors++;
            $display("FAIL wr_done_hold: state=%0d required 7", state);
        end
        checks++;
        if (n_addr != 1 || n_dm != 1 || n_sr != 0 || n_miso != 0) begin
            errors++;
            $display("FAIL wr_pulse_counts: addr=%0d dm=%0d sr=%0d miso=%0d required 1 1 0 0",
                     n_addr, n_dm, n_sr, n_miso);
        end
        end_frame();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL wr_release: state=%0d required 0", state);
        end
    endtask

    task automatic test_read_frame();
        clear_tallies();
        send_addr(1'b1);
        checks++;
        if (state !== 3'd3 || sr_we !== 1'b1) begin
            errors++;
            $display("FAIL rd_load: state=%0d sr_we=%b required 3/1", state, sr_we);
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd4 || miso_buff !== 1'b1) begin
            errors++;
            $display("FAIL rd_send_enter: state=%0d miso_buff=%b required 4/1", state, miso_buff);
        end
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL rd_neg_7th: state=%0d required 4", state);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (state !== 3'd7 || miso_buff !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: state=%0d miso_buff=%b required 7/0", state, miso_buff);
        end
        checks++;
        if (n_addr != 1 || n_sr != 1 || n_miso != 8 || n_dm != 0) begin
            errors++;
            $display("FAIL rd_pulse_counts: addr=%0d sr=%0d miso=%0d dm=%0d required 1 1 8 0",
                     n_addr, n_sr, n_miso, n_dm);
        end
        end_frame();
    endtask

    task automatic test_abort();
        clear_tallies();
        send_addr(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        cs_cond = 1'b1;
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL abort_state: state=%0d required 0", state);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        checks++;
        if (n_dm != 0 || state !== 3'd0) begin
            errors++;
            $display("FAIL abort_no_dm: dm=%0d state=%0d required 0/0", n_dm, state);
        end
    endtask

    task automatic test_wrong_edge();
        cs_cond = 1'b0;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL we_addr_neg_ignored: state=%0d required 1", state);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL we_addr_8th_pos: state=%0d required 2", state);
        end
        sr_lsb = 1'b1;
        cyc(1'b0, 1'b0);
        sr_lsb = 1'b0;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b1);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL we_send_pos_ignored: state=%0d required 4", state);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (state !== 3'd7) begin
            errors++;
            $display("FAIL we_send_8th_neg: state=%0d required 7", state);
        end
        end_frame();
    endtask

    task automatic test_reset_mid_read();
        send_addr(1'b1);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        reset = 1'b1;
        cyc(1'b0, 1'b1);
        reset = 1'b0;
        checks++;
        if (state !== 3'd0 || {addr_we, sr_we, dm_we, miso_buff} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_read: state=%0d outs=%b required 0/0000",
                     state, {addr_we, sr_we, dm_we, miso_buff});
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL rst_fresh_start: state=%0d required 1", state);
        end
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL rst_fresh_count7: state=%0d required 1", state);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd2 || addr_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_addr: state=%0d addr_we=%b required 2/1", state, addr_we);
        end
        end_frame();
    endtask

    task automatic test_priority();
        clear_tallies();
        send_addr(1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        cs_cond = 1'b1;
        cyc(1'b1, 1'b0);
        checks++;
        if (state !== 3'd0 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL prio_abort: state=%0d dm_we=%b required 0/0", state, dm_we);
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (n_dm != 0) begin
            errors++;
            $display("FAIL prio_no_dm: dm pulses=%0d required 0", n_dm);
        end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_frame();
        test_abort();
        test_wrong_edge();
        test_reset_mid_read();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
